shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one 8-bit shift/rotate unit between NUM_REQ requesters using round-robin arbitration.
- Each requester presents a valid/ready command: data, shift amount and op code.
- The granted command is executed in the same cycle and held in a one-entry response register, tagged with the requester id.
- Sits between the ALU-side command sources and the shift datapath; it is the only path to the shifter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must equal clog2(NUM_REQ) (minimum 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester command valid
- req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high per cycle
- req_data  input  8*NUM_REQ  operands; requester i uses bits [8i+7:8i]
- req_amt  input  3*NUM_REQ  shift amounts; requester i uses bits [3i+2:3i]
- req_op  input  3*NUM_REQ  op codes; requester i uses bits [3i+2:3i]
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  ID_W  requester index that owns the response
- rsp_data  output  8  shifted/rotated result
- busy_cnt  output  16  total accepted commands since reset; saturates at 0xFFFF

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy_cnt=0.
  - Round-robin pointer=0; FSM=EMPTY.
  - req_ready is all-zero while in reset.
- FSM states and transitions:
  - EMPTY: the response register is free.
  - FULL: the response register holds an unconsumed result.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY when rsp_ready=1 and there is no grant.
  - FULL -> FULL when rsp_ready=1 and there is a grant (back-to-back).
  - FULL holds while rsp_ready=0.
- Grant condition: can_accept = (state==EMPTY) | rsp_ready. Grants only when can_accept and at least one req_valid bit is set.
- Arbitration:
  - Select the first set req_valid bit, searching upward from the pointer index and wrapping modulo NUM_REQ.
  - req_ready[g]=1 only for the granted index g. This is combinational from req_valid, the pointer, state and rsp_ready.
  - After a grant, pointer = (g+1) mod NUM_REQ. With no grant, the pointer is unchanged.
  - Requesters must hold valid and command stable until ready. A deasserted valid before grant is simply not considered.
- Execution: combinational on the granted command; the result is registered on the grant edge. Latency: rsp_valid rises the cycle after req_valid&req_ready.
- Op codes (sh = amt, 0..7):
  - 000 logical left: zero fill.
  - 001 logical right: zero fill.
  - 010 arithmetic left: identical to 000.
  - 011 arithmetic right: sign (bit 7) fill.
  - 100 rotate left.
  - 101 rotate right.
  - 110, 111: pass data unchanged.
  - Rotate by 0 returns data unchanged; no shift width exceeds 8 bits internally.
- Response:
  - rsp_data and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
  - A response is consumed on rsp_valid&rsp_ready. A new result may load in the same cycle, giving full throughput of 1 op/cycle.
- busy_cnt increments by 1 per grant and stops at 0xFFFF.
- Boundary conditions:
  - Single requester continuously valid: granted every cycle the response path is free.
  - All requesters valid: served in order ptr, ptr+1, ... with no starvation. Each waits at most NUM_REQ-1 grants.
  - rsp_ready=1 while EMPTY is harmless.
  - Reset asserted mid-operation discards the pending response and resets the pointer. No req_ready is issued in the reset cycle.

Test Plan:
- Reset then idle: after rst_n release with no valids -> rsp_valid=0, req_ready=0, busy_cnt=0 for 10 cycles.
- Op coverage (req0, rsp_ready=1):
  - data 0xB4, amt 3, ops 000..111 -> rsp_data 0xA0, 0x16, 0xA0, 0xF6, 0xA5, 0x96, 0xB4, 0xB4 on consecutive cycles, rsp_id=0.
  - Rotate with amt=0 on 0x81 -> 0x81.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1. Each req_ready pulses once per 4 cycles.
- Backpressure:
  - req2 valid, rsp_ready=0 -> one grant, then FULL holds rsp_data/rsp_id for 5 cycles with req_ready=0.
  - Raise rsp_ready -> next command accepted in the same cycle as consumption.
- Pointer wrap: only req3 then req0 and req3 valid after a grant to 3 -> req0 granted before req3.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> rsp_valid=0 immediately, busy_cnt=0, next grant starts at req0.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one 8-bit shift/rotate unit
// between NUM_REQ requesters. The granted command is executed in the grant
// cycle and its result is held in a one-entry response register tagged with
// the requester id. Throughput is one op per cycle when the consumer keeps
// rsp_ready high.

// Combinational 8-bit shift/rotate datapath.
module shift_unit (
  input  logic [7:0] data,
  input  logic [2:0] amt,
  input  logic [2:0] op,
  output logic [7:0] res
);

  logic [15:0] dbl_l;
  logic [15:0] dbl_r;

  // Rotates are taken from a doubled operand so no shift ever exceeds the
  // operand width and rotate-by-0 falls out naturally.
  always_comb begin
    dbl_l = {data, data} << amt;
    dbl_r = {data, data} >> amt;
    res   = data;
    case (op)
      3'b000:  res = data << amt;
      3'b001:  res = data >> amt;
      3'b010:  res = data << amt;
      3'b011:  res = 8'($signed(data) >>> amt);
      3'b100:  res = dbl_l[15:8];
      3'b101:  res = dbl_r[7:0];
      default: res = data;
    endcase
  end

endmodule

module shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [3*NUM_REQ-1:0] req_amt,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic [15:0]          busy_cnt
);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amt;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  cmd_t [NUM_REQ-1:0]     cmd;
  cmd_t                   sel_cmd;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        ptr_nxt;
  logic [ID_W-1:0]        gnt_idx;
  logic                   gnt_any;
  logic                   can_accept;
  int                     scan_idx;
  logic [7:0]             exe_res;
  logic [ID_W-1:0]        rsp_id_q;
  logic [7:0]             rsp_data_q;
  logic [15:0]            cnt_q;

  // Unpack the flat per-requester command buses.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign cmd[i].data = req_data[8*i +: 8];
    assign cmd[i].amt  = req_amt[3*i +: 3];
    assign cmd[i].op   = req_op[3*i +: 3];
  end

  // The response slot is free when empty or when it drains this cycle.
  assign can_accept = (state_q == EMPTY) | rsp_ready;

  // Round-robin search starting at the pointer and wrapping; gated by reset
  // so no requester is accepted while the block is held in reset.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    if (rst_n && can_accept) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = int'(ptr_q) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (!gnt_any && req_valid[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(scan_idx);
        end
      end
    end
  end

  // One-hot accept strobe for the granted requester only.
  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Pointer moves to the requester after the winner, wrapping modulo NUM_REQ.
  always_comb begin
    ptr_nxt = gnt_idx + ID_W'(1);
    if (gnt_idx == ID_W'(NUM_REQ - 1)) ptr_nxt = '0;
  end

  assign sel_cmd = cmd[gnt_idx];

  shift_unit u_shift (
    .data (sel_cmd.data),
    .amt  (sel_cmd.amt),
    .op   (sel_cmd.op),
    .res  (exe_res)
  );

  // Response-slot FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (gnt_any) state_d = FULL;
      FULL:  if (rsp_ready && !gnt_any) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Pointer, response payload and saturating grant counter update on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
    end else if (gnt_any) begin
      ptr_q      <= ptr_nxt;
      rsp_id_q   <= gnt_idx;
      rsp_data_q <= exe_res;
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy_cnt  = cnt_q;

endmodule
